// File: rtl/event_arbiter.sv
// Edge-to-event arbiter: turns rising edges of five debounced levels into single events offered over valid/ready,
// one pending slot per source, cooldown after each grant. Define EVT_ROUND_ROBIN_EN for rotating priority.
module event_arbiter #(
   parameter int COOLDOWN = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_test,
   input  logic       btn_energia,
   input  logic       btn_medicina,
   input  logic       sens_ult,
   input  logic       sens_fot,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [2:0] evt_code,
   output logic [4:0] pending,
   output logic [7:0] drop_cnt
);

   localparam int CNT_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

   typedef enum logic [1:0] {IDLE, OFFER, COOL} state_t;

   state_t           state, state_d;
   logic [4:0]       in_vec, prev, edge_vec, grant_vec, pending_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             valid_d, dropped;
   logic [2:0]       code_d, sel_idx, gidx;
   logic [7:0]       drop_d;
`ifdef EVT_ROUND_ROBIN_EN
   logic [2:0]       rr_last, rr_d;
`endif

   // Bit order matches evt_code - 1: test, energia, medicina, ult, fot.
   assign in_vec   = {sens_fot, sens_ult, btn_medicina, btn_energia, btn_test};
   assign edge_vec = in_vec & ~prev;

`ifdef EVT_ROUND_ROBIN_EN
   always_comb begin
      int   idx;
      logic found;
      sel_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < 5; k++) begin
         idx = (int'(rr_last) + 1 + k) % 5;
         if (!found && pending[idx]) begin
            sel_idx = 3'(idx);
            found   = 1'b1;
         end
      end
   end
`else
   always_comb begin
      if (pending[0])      sel_idx = 3'd0;
      else if (pending[2]) sel_idx = 3'd2;
      else if (pending[1]) sel_idx = 3'd1;
      else if (pending[4]) sel_idx = 3'd4;
      else                 sel_idx = 3'd3;
   end
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state;
      valid_d   = evt_valid;
      code_d    = evt_code;
      cnt_d     = cnt;
      grant_vec = '0;
      gidx      = evt_code - 3'd1;
`ifdef EVT_ROUND_ROBIN_EN
      rr_d      = rr_last;
`endif
      case (state)
         IDLE: begin
            if (|pending) begin
               valid_d = 1'b1;
               code_d  = sel_idx + 3'd1;
               state_d = OFFER;
            end else begin
               code_d = 3'd0;
            end
         end
         OFFER: begin
            if (evt_ready) begin
               valid_d   = 1'b0;
               code_d    = 3'd0;
               grant_vec = 5'd1 << gidx;
`ifdef EVT_ROUND_ROBIN_EN
               rr_d      = gidx;
`endif
               if (COOLDOWN == 0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = COOL;
               end
            end
         end
         COOL: begin
            if (cnt == '0) state_d = IDLE;
            else           cnt_d   = cnt - 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // A new edge on the source being granted re-arms its slot rather than counting as a drop.
      pending_d = (pending & ~grant_vec) | edge_vec;
      dropped   = |(edge_vec & pending & ~grant_vec);
      drop_d    = (dropped && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         prev      <= in_vec;
         pending   <= '0;
         drop_cnt  <= '0;
         evt_valid <= 1'b0;
         evt_code  <= 3'd0;
         cnt       <= '0;
`ifdef EVT_ROUND_ROBIN_EN
         rr_last   <= 3'd4;
`endif
      end else begin
         state     <= state_d;
         prev      <= in_vec;
         pending   <= pending_d;
         drop_cnt  <= drop_d;
         evt_valid <= valid_d;
         evt_code  <= code_d;
         cnt       <= cnt_d;
`ifdef EVT_ROUND_ROBIN_EN
         rr_last   <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_event_arbiter.sv
// Directed bench for event_arbiter with COOLDOWN = 4; expected values are hand-derived from the cycle timing.
module tb_event_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_test, btn_energia, btn_medicina, sens_ult, sens_fot, evt_ready;
   logic       evt_valid;
   logic [2:0] evt_code;
   logic [4:0] pending;
   logic [7:0] drop_cnt;

   int passed = 0;
   int total  = 0;

   event_arbiter #(.COOLDOWN(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_test     (btn_test),
      .btn_energia  (btn_energia),
      .btn_medicina (btn_medicina),
      .sens_ult     (sens_ult),
      .sens_fot     (sens_fot),
      .evt_ready    (evt_ready),
      .evt_valid    (evt_valid),
      .evt_code     (evt_code),
      .pending      (pending),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic wait_valid(input string tag, input int max);
      int n = 0;
      while (!evt_valid && n < max) begin
         step();
         n++;
      end
      check({tag, "_timeout"}, 32'(evt_valid), 32'd1);
   endtask

   initial begin
      int seen, lows, bad;
      logic [2:0] first_code, second_code;

      reset = 1'b1; btn_test = 1'b1; btn_energia = 1'b0; btn_medicina = 1'b0;
      sens_ult = 1'b0; sens_fot = 1'b0; evt_ready = 1'b0;
      steps(3);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_code",  32'(evt_code),  32'd0);
      check("rst_pend",  32'(pending),   32'd0);
      check("rst_drop",  32'(drop_cnt),  32'd0);

      // Level already high at reset release must not generate an event.
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (evt_valid || pending != 5'd0) seen++;
      end
      check("held_high_no_event", 32'(seen), 32'd0);
      btn_test = 1'b0;
      evt_ready = 1'b1;
      step();

      // Medicina: pending at t+1, valid at t+2, accepted, then 5 low cycles before the next offer.
      btn_medicina = 1'b1;
      step();
      check("med_pend",      32'(pending),   32'b00100);
      check("med_pend_nov",  32'(evt_valid), 32'd0);
      step();
      check("med_valid",     32'(evt_valid), 32'd1);
      check("med_code",      32'(evt_code),  32'd3);
      btn_medicina = 1'b0;
      step();
      check("med_accepted",  32'(evt_valid), 32'd0);
      check("med_cleared",   32'(pending),   32'd0);
      btn_medicina = 1'b1;
      lows = evt_valid ? 0 : 1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (!evt_valid) lows++;
      end
      check("cool_low_cycles", 32'(lows), 32'd5);
      step();
      check("cool_reoffer",      32'(evt_valid), 32'd1);
      check("cool_reoffer_code", 32'(evt_code),  32'd3);
      btn_medicina = 1'b0;
      step();
      check("med2_accepted", 32'(evt_valid), 32'd0);
      steps(6);

      // A test grant so the rotating build starts its next search at energia.
      btn_test = 1'b1;
      step();
      check("test_pend", 32'(pending), 32'b00001);
      step();
      check("test_code", 32'(evt_code), 32'd1);
      btn_test = 1'b0;
      steps(7);

      // Simultaneous test + energia edges.
      btn_test = 1'b1; btn_energia = 1'b1;
      step();
      check("dual_pend", 32'(pending), 32'b00011);
`ifdef EVT_ROUND_ROBIN_EN
      first_code = 3'd2; second_code = 3'd1;
`else
      first_code = 3'd1; second_code = 3'd2;
`endif
      step();
      check("dual_first", 32'(evt_code), 32'(first_code));
      step();
      wait_valid("dual_second", 20);
      check("dual_second", 32'(evt_code), 32'(second_code));
      btn_test = 1'b0; btn_energia = 1'b0;
      step();
      check("dual_done_pend", 32'(pending), 32'd0);
      steps(6);

      // Stalled consumer: offer holds; repeated ult edges are dropped and saturate the counter.
      evt_ready = 1'b0;
      sens_ult = 1'b1;
      steps(2);
      check("ult_code", 32'(evt_code), 32'd4);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!(evt_valid === 1'b1 && evt_code === 3'd4)) bad++;
      end
      check("ult_stable", 32'(bad), 32'd0);
      sens_ult = 1'b0; step();
      sens_ult = 1'b1; step();
      check("drop_one", 32'(drop_cnt), 32'd1);
      for (int i = 0; i < 300; i++) begin
         sens_ult = 1'b0; step();
         sens_ult = 1'b1; step();
      end
      check("drop_sat",      32'(drop_cnt), 32'd255);
      check("ult_still",     32'(evt_code), 32'd4);
      check("ult_pend_held", 32'(pending),  32'b01000);
      evt_ready = 1'b1;
      step();
      check("ult_accepted", 32'(evt_valid), 32'd0);
      check("ult_cleared",  32'(pending),   32'd0);
      evt_ready = 1'b0;
      steps(8);

      // Reset while code 5 is offered: everything clears, a later edge works normally.
      sens_fot = 1'b1;
      steps(2);
      check("fot_offer", 32'(evt_code), 32'd5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_valid", 32'(evt_valid), 32'd0);
      check("mid_rst_code",  32'(evt_code),  32'd0);
      check("mid_rst_pend",  32'(pending),   32'd0);
      check("mid_rst_drop",  32'(drop_cnt),  32'd0);
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (evt_valid) seen++;
      end
      check("post_rst_quiet", 32'(seen), 32'd0);
      sens_fot = 1'b0; step();
      sens_fot = 1'b1; step();
      check("fot_pend", 32'(pending), 32'b10000);
      step();
      check("fot_valid", 32'(evt_valid), 32'd1);
      check("fot_code",  32'(evt_code),  32'd5);
      evt_ready = 1'b1;
      step();
      check("fot_accepted", 32'(evt_valid), 32'd0);
      check("fot_drop",     32'(drop_cnt),  32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
